bpa_seq_ctrl: RTL and testbench
===============================

BPA_SEQ_CTRL -- requirements
Module: bpa_seq_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; legal range 2..8; operand width W = 4*NIBBLES.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  operation request; sampled only in IDLE.
REQ-005 Port: sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 Port: op_a  input  W  operand A; sampled with start.
REQ-007 Port: op_b  input  W  operand B; sampled with start.
REQ-008 Port: busy  output  1  high while slices are being sequenced.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: result  output  W  sum/difference.
REQ-011 Port: cout  output  1  final carry out of the top slice (for sub: 1 = no borrow).
REQ-012 Port: ovf  output  1  two's-complement overflow.
REQ-013 Port: zero  output  1  result == 0.
REQ-014 Port: slice_a  output  4  nibble A to external 4-bit adder a.
REQ-015 Port: slice_b  output  4  nibble B to external 4-bit adder b.
REQ-016 Port: slice_cin  output  1  carry to external adder cin.
REQ-017 Port: slice_s  input  4  external adder sum s (combinational from slice_a/b/cin).
REQ-018 Port: slice_cout  input  1  external adder cout.

Function
REQ-019 FSM states IDLE, RUN, DONE; encoding at implementer's discretion.
REQ-020 IDLE with start=1: capture a_reg<=op_a, b_reg<=(sub ? ~op_b : op_b), carry<=sub, idx<=0, result<=0; go to RUN.
REQ-021 IDLE with start=0: hold all registers and outputs.
REQ-022 RUN: slice_a = a_reg[4*idx+3:4*idx], slice_b = b_reg[4*idx+3:4*idx], slice_cin = carry; combinational from registers.
REQ-023 RUN, each edge: result nibble idx <= slice_s; carry <= slice_cout; idx <= idx+1.
REQ-024 RUN with idx == NIBBLES-1: after the capture, go to DONE; cout<=slice_cout; zero/ovf computed from the completed result.
REQ-025 ovf = (a_reg[W-1] == b_reg[W-1]) && (result[W-1] != a_reg[W-1]), using stored (possibly inverted) b_reg.
REQ-026 DONE: done=1 for exactly one cycle; unconditionally go to IDLE next edge.
REQ-027 busy = 1 in RUN only; exactly NIBBLES cycles per operation.
REQ-028 Latency: start accepted at edge k; done high in the cycle after edge k+NIBBLES; next start accepted at edge k+NIBBLES+1 at earliest.
REQ-029 start in RUN or DONE is ignored; not queued.
REQ-030 Outside RUN: slice_a=0, slice_b=0, slice_cin=0.
REQ-031 result, cout, ovf, zero hold their values from DONE until the next accepted start.
REQ-032 Operands are not re-sampled during RUN; op_a/op_b/sub changes mid-operation have no effect.

Reset
REQ-033 rst=1 at an edge: state<=IDLE, idx<=0, carry<=0, result<=0, cout/ovf/zero<=0, busy=0, done=0, slice outputs 0.
REQ-034 rst takes priority over start and over any RUN/DONE activity; an aborted operation produces no done pulse.

Verification (NIBBLES=4; bench models slice adder as slice_s/slice_cout = slice_a+slice_b+slice_cin)
REQ-035 Add 0x1234+0x0FCD -> slice_a 4,3,2,1; slice_b D,C,F,0; slice_cin 0,1,1,1; result 0x2201, cout 0, ovf 0, zero 0; done exactly 5 edges after the start edge.
REQ-036 Add 0xFFFF+0x0001 -> result 0x0000, cout 1, zero 1, ovf 0.
REQ-037 Sub 0x0005-0x0007 -> result 0xFFFE, cout 0, ovf 0, zero 0.
REQ-038 Add 0x7FFF+0x0001 -> result 0x8000, ovf 1, cout 0; sub 0x8000-0x0001 -> 0x7FFF, ovf 1, cout 1.
REQ-039 start held high continuously with changing operands -> only operations starting at IDLE are accepted; every result matches the operands sampled at acceptance; busy is never high for more than 4 consecutive cycles.
REQ-040 rst pulsed during the 2nd RUN cycle -> next cycle busy=0, result 0, all flags 0, no done pulse; a following start completes normally.

Source files
------------

// File: rtl/bpa_seq_ctrl.sv
// Bit-serial-by-nibble add/subtract sequencer: feeds one 4-bit slice per cycle
// to an external 4-bit adder, ripples the carry through a register, and assembles the result.
module bpa_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   zero,
  output logic [3:0]             slice_a,
  output logic [3:0]             slice_b,
  output logic                   slice_cin,
  input  logic [3:0]             slice_s,
  input  logic                   slice_cout
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     result_reg;
  logic [W-1:0]     result_next;
  logic [IDXW-1:0]  idx_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             last_slice;

  logic [3:0]       a_nib [NIBBLES];
  logic [3:0]       b_nib [NIBBLES];

  assign last_slice = (idx_reg == IDXW'(NIBBLES - 1));

  // result_next is the result register with the current slice sum merged in,
  // so the final flags can be derived in the same edge that stores the top nibble.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign result_next[4*gi +: 4] = (idx_reg == IDXW'(gi)) ? slice_s
                                                             : result_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    if (state_reg == S_RUN) begin
      slice_a   = a_nib[idx_reg];
      slice_b   = b_nib[idx_reg];
      slice_cin = carry_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            a_reg      <= op_a;
            b_reg      <= sub ? ~op_b : op_b;
            carry_reg  <= sub;
            idx_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= S_RUN;
          end
        end
        S_RUN: begin
          result_reg <= result_next;
          carry_reg  <= slice_cout;
          idx_reg    <= idx_reg + 1'b1;
          if (last_slice) begin
            cout_reg  <= slice_cout;
            zero_reg  <= (result_next == '0);
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (result_next[W-1] != a_reg[W-1]);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign cout   = cout_reg;
  assign ovf    = ovf_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_bpa_seq_ctrl.sv
// Self-checking bench for bpa_seq_ctrl: behavioural 4-bit slice adder, vector table
// of operations, plus held-start and reset-abort sequences.
module tb_bpa_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sub;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic          slice_cin;
  logic [3:0]    slice_s;
  logic          slice_cout;

  bpa_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sub        (sub),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout),
    .ovf        (ovf),
    .zero       (zero),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_s    (slice_s),
    .slice_cout (slice_cout)
  );

  // External 4-bit adder model
  assign {slice_cout, slice_s} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs [8];

  int errors = 0;
  int checks = 0;

  int          lat;
  int          bcnt;
  logic        got_done;
  logic        done_after;
  logic        busy_after;
  logic [3:0]  cap_a   [NIB];
  logic [3:0]  cap_b   [NIB];
  logic        cap_cin [NIB];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the operand inputs after acceptance, and record
  // slice traffic, latency (negedges from accept edge to done) and busy cycles.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; sub = s; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; sub = ~s; op_a = ~a; op_b = b ^ 16'h5A5A;
    lat = 0; bcnt = 0; got_done = 1'b0;
    while (!got_done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) begin
        if (bcnt < NIB) begin
          cap_a[bcnt]   = slice_a;
          cap_b[bcnt]   = slice_b;
          cap_cin[bcnt] = slice_cin;
        end
        bcnt++;
      end
      if (done) got_done = 1'b1;
    end
    @(negedge clk);
    done_after = done;
    busy_after = busy;
    $display("op sub=%0b a=%h b=%h result=%h cout=%0b ovf=%0b zero=%0b latency=%0d busy_cycles=%0d",
             s, a, b, result, cout, ovf, zero, lat, bcnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   exp_sa  [NIB];
    logic [3:0]   exp_sb  [NIB];
    logic         exp_cin [NIB];
    int           left;
    int           run;
    int           maxrun;
    logic [W-1:0] ha;
    logic [W-1:0] hb;
    logic         hs;
    logic [W-1:0] exp_r;
    logic         seen;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    exp_sa  = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_sb  = '{4'hD, 4'hC, 4'hF, 4'h0};
    exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check16("rst_result", result, 16'h0000);
    check1("rst_cout", cout, 1'b0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_zero", zero, 1'b0);
    check1("rst_slice_cin", slice_cin, 1'b0);
    checki("rst_slice_ab", int'({slice_a, slice_b}), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b);
      check16($sformatf("vec%0d_result", i), result, vecs[i].r);
      check1($sformatf("vec%0d_cout", i), cout, vecs[i].co);
      check1($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
      check1($sformatf("vec%0d_zero", i), zero, vecs[i].z);
      checki($sformatf("vec%0d_latency", i), lat, NIB + 1);
      checki($sformatf("vec%0d_busy_cycles", i), bcnt, NIB);
      check1($sformatf("vec%0d_done_pulse", i), done_after, 1'b0);
      check1($sformatf("vec%0d_busy_after", i), busy_after, 1'b0);
      if (i == 0) begin
        for (int j = 0; j < NIB; j++) begin
          checki($sformatf("vec0_slice_a%0d", j), int'(cap_a[j]), int'(exp_sa[j]));
          checki($sformatf("vec0_slice_b%0d", j), int'(cap_b[j]), int'(exp_sb[j]));
          check1($sformatf("vec0_slice_cin%0d", j), cap_cin[j], exp_cin[j]);
        end
      end
      repeat (3) @(negedge clk);
      check16($sformatf("vec%0d_hold", i), result, vecs[i].r);
    end

    // start held high with changing operands: only IDLE starts are taken
    @(negedge clk);
    left = 0; run = 0; maxrun = 0; exp_r = '0;
    for (int c = 0; c < 40; c++) begin
      ha = 16'($urandom);
      hb = 16'($urandom);
      hs = 1'($urandom_range(0, 1));
      start = 1'b1; sub = hs; op_a = ha; op_b = hb;
      @(posedge clk);
      if (left > 0) left--;
      else begin
        left  = NIB + 1;
        exp_r = hs ? (ha - hb) : (ha + hb);
      end
      @(negedge clk);
      check1($sformatf("held_busy_c%0d", c), busy, left >= 2);
      check1($sformatf("held_done_c%0d", c), done, left == 1);
      if (left == 1) check16($sformatf("held_result_c%0d", c), result, exp_r);
      if (busy) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    start = 1'b0;
    checki("held_max_busy_run", maxrun, NIB);
    repeat (2) @(negedge clk);

    // Reset during the second RUN cycle aborts the operation
    do_op(1'b0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h0FCD;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check16("abort_result", result, 16'h0000);
    check1("abort_cout", cout, 1'b0);
    check1("abort_ovf", ovf, 1'b0);
    check1("abort_zero", zero, 1'b0);
    checki("abort_slice_a", int'(slice_a), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check1("abort_no_activity", seen, 1'b0);
    do_op(1'b0, 16'h1234, 16'h0FCD);
    check16("post_abort_result", result, 16'h2201);
    checki("post_abort_latency", lat, NIB + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
